spm_min_led_checker: RTL and testbench

SPM_MIN_LED_CHECKER -- requirements
Module: spm_min_led_checker

---
 rtl/spm_min_led_checker.sv | 126 ++++++++++++
 tb/tb_spm_min_led_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spm_min_led_checker.sv
// LED counter sequence checker: locks on LOCK_COUNT consecutive +1 steps, flags errors and inactivity timeouts.
// Latency: outputs update two clk edges after din changes. Backpressure: none, din is sampled every cycle.
// Optional SPM_CHK_PERIOD_CHECK_EN: in a run or in lock, a step whose spacing differs from the previous spacing counts as an error.
module spm_min_led_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter logic [23:0] TIMEOUT    = 24'd16777215
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  output logic        locked,
  output logic        err,
  output logic        timeout,
  output logic [7:0]  err_cnt,
  output logic [23:0] period
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  localparam logic [3:0]  LOCK_RUN = 4'(LOCK_COUNT - 1);
  localparam logic [23:0] GAP_MAX  = 24'hFFFFFF;

  state_t      state;
  logic [7:0]  s;
  logic [7:0]  last;
  logic [23:0] gap;
  logic [3:0]  run;

  logic evt;
  logic good_val;
  logic period_ok;
  logic good;
  logic bad_evt;
  logic to_hit;

  assign evt      = (s != last);
  assign good_val = (s == 8'(last + 8'd1));

`ifdef SPM_CHK_PERIOD_CHECK_EN
  // gap already equals the cycles since the previous event, so it is the new period
  assign period_ok = !(((state == ACQ) && (run != 4'd0)) || (state == LOCKED)) || (gap == period);
`else
  assign period_ok = 1'b1;
`endif

  assign good    = good_val && period_ok;
  assign bad_evt = evt && !good && (state != IDLE);
  assign to_hit  = (state != IDLE) && !evt && (gap == TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s       <= 8'd0;
      last    <= 8'd0;
      gap     <= 24'd0;
      run     <= 4'd0;
      period  <= 24'd0;
      err_cnt <= 8'd0;
      locked  <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      s       <= din;
      last    <= s;
      err     <= bad_evt;
      timeout <= 1'b0;

      if (evt) begin
        gap    <= 24'd1;
        period <= gap;
      end else if (gap != GAP_MAX) begin
        gap <= gap + 24'd1;
      end

      if (bad_evt && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (evt) begin
            state <= ACQ;
            run   <= 4'd0;
          end
        end
        ACQ: begin
          if (evt) begin
            if (good) begin
              run <= run + 4'd1;
              if (run == LOCK_RUN) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              run <= 4'd0;
            end
          end else if (to_hit) begin
            state   <= IDLE;
            run     <= 4'd0;
            timeout <= 1'b1;
          end
        end
        LOCKED: begin
          if (evt) begin
            if (!good) begin
              state  <= ACQ;
              run    <= 4'd0;
              locked <= 1'b0;
            end
          end else if (to_hit) begin
            state   <= IDLE;
            run     <= 4'd0;
            locked  <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          run    <= 4'd0;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spm_min_led_checker.sv
// Directed bench for spm_min_led_checker with LOCK_COUNT=4, TIMEOUT=1000.
`timescale 1ns/100ps
module tb_spm_min_led_checker;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic        locked;
  logic        err;
  logic        timeout;
  logic [7:0]  err_cnt;
  logic [23:0] period;

  int total = 0;
  int bad   = 0;

`ifdef SPM_CHK_PERIOD_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  spm_min_led_checker #(.LOCK_COUNT(4), .TIMEOUT(24'd1000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .locked  (locked),
    .err     (err),
    .timeout (timeout),
    .err_cnt (err_cnt),
    .period  (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // d is driven for hold cycles; checks at the 2nd negedge after the change and at the end
  typedef struct {
    logic [7:0]  d;
    int          hold;
    logic        lk2;
    logic [7:0]  cnt2;
    bit          chkp;
    logic [23:0] per;
    int          errs;
    int          tos;
    logic        lkend;
  } row_t;

  row_t tbl_a[$];
  row_t tbl_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic row_t mk(input logic [7:0] d, input int hold, input logic lk2,
                              input logic [7:0] cnt2, input bit chkp, input logic [23:0] per,
                              input int errs, input int tos, input logic lkend);
    row_t r;
    r.d = d; r.hold = hold; r.lk2 = lk2; r.cnt2 = cnt2; r.chkp = chkp;
    r.per = per; r.errs = errs; r.tos = tos; r.lkend = lkend;
    return r;
  endfunction

  task automatic apply_row(input row_t r, input string tag);
    int ne;
    int nt;
    ne = 0;
    nt = 0;
    din = r.d;
    for (int i = 1; i <= r.hold; i++) begin
      @(negedge clk);
      ne += int'(err);
      nt += int'(timeout);
      if (i == 2) begin
        chk({tag, "_locked"}, 32'(locked), 32'(r.lk2));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(r.cnt2));
        if (r.chkp) chk({tag, "_period"}, 32'(period), 32'(r.per));
      end
    end
    chk({tag, "_err_pulses"}, 32'(ne), 32'(r.errs));
    chk({tag, "_timeout_pulses"}, 32'(nt), 32'(r.tos));
    chk({tag, "_locked_end"}, 32'(locked), 32'(r.lkend));
  endtask

  initial begin
    int ne;

    // lock acquisition, wrap-through-zero while locked, relock after a jump
    tbl_a.push_back(mk(8'h00,  10, 0, 8'd0, 0, 24'd0,   0, 0, 0));
    tbl_a.push_back(mk(8'h01, 256, 0, 8'd0, 0, 24'd0,   0, 0, 0));
    tbl_a.push_back(mk(8'h02, 256, 0, 8'd0, 1, 24'd256, 0, 0, 0));
    tbl_a.push_back(mk(8'h03, 256, 0, 8'd0, 1, 24'd256, 0, 0, 0));
    tbl_a.push_back(mk(8'h04, 256, 0, 8'd0, 1, 24'd256, 0, 0, 0));
    tbl_a.push_back(mk(8'h05, 256, 1, 8'd0, 1, 24'd256, 0, 0, 1));
    tbl_a.push_back(mk(8'hFA, 256, 0, 8'd1, 1, 24'd256, 1, 0, 0));
    tbl_a.push_back(mk(8'hFB, 256, 0, 8'd1, 1, 24'd256, 0, 0, 0));
    tbl_a.push_back(mk(8'hFC, 256, 0, 8'd1, 1, 24'd256, 0, 0, 0));
    tbl_a.push_back(mk(8'hFD, 256, 0, 8'd1, 1, 24'd256, 0, 0, 0));
    tbl_a.push_back(mk(8'hFE, 256, 1, 8'd1, 1, 24'd256, 0, 0, 1));
    tbl_a.push_back(mk(8'hFF, 256, 1, 8'd1, 1, 24'd256, 0, 0, 1));
    tbl_a.push_back(mk(8'h00, 256, 1, 8'd1, 1, 24'd256, 0, 0, 1));
    tbl_a.push_back(mk(8'h01, 256, 1, 8'd1, 1, 24'd256, 0, 0, 1));
    tbl_a.push_back(mk(8'h03, 256, 0, 8'd2, 1, 24'd256, 1, 0, 0));
    tbl_a.push_back(mk(8'h04, 256, 0, 8'd2, 1, 24'd256, 0, 0, 0));
    tbl_a.push_back(mk(8'h05, 256, 0, 8'd2, 1, 24'd256, 0, 0, 0));
    tbl_a.push_back(mk(8'h06, 256, 0, 8'd2, 1, 24'd256, 0, 0, 0));
    tbl_a.push_back(mk(8'h07, 200, 1, 8'd2, 1, 24'd256, 0, 0, 1));
    // short step, then inactivity timeout; then event exactly on the timeout cycle
    tbl_a.push_back(mk(8'h08, 1005, !PCHK, PCHK ? 8'd3 : 8'd2, 1, 24'd200,
                       PCHK ? 1 : 0, 1, 0));
    tbl_a.push_back(mk(8'h09, 1000, 0, PCHK ? 8'd3 : 8'd2, 1, 24'd1005, 0, 0, 0));
    tbl_a.push_back(mk(8'h0A,    5, 0, PCHK ? 8'd3 : 8'd2, 1, 24'd1000, 0, 0, 0));

    // relock after the err_cnt saturation burst
    tbl_b.push_back(mk(8'h81, 256, 0, 8'hFF, 1, 24'd256, 0, 0, 0));
    tbl_b.push_back(mk(8'h82, 256, 0, 8'hFF, 1, 24'd256, 0, 0, 0));
    tbl_b.push_back(mk(8'h83, 256, 0, 8'hFF, 1, 24'd256, 0, 0, 0));
    tbl_b.push_back(mk(8'h84, 256, 1, 8'hFF, 1, 24'd256, 0, 0, 1));

    rst_n = 1'b0;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_locked",  32'(locked),  32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_period",  32'(period),  32'd0);
    rst_n = 1'b1;

    foreach (tbl_a[i]) apply_row(tbl_a[i], $sformatf("a%0d", i));

    // 300 back-to-back bad jumps saturate err_cnt
    ne = 0;
    for (int k = 0; k < 300; k++) begin
      din = k[0] ? 8'h80 : 8'h40;
      repeat (2) begin
        @(negedge clk);
        ne += int'(err);
      end
    end
    chk("sat_err_pulses", 32'(ne), 32'd300);
    chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
    chk("sat_locked", 32'(locked), 32'd0);
    repeat (254) @(negedge clk);

    foreach (tbl_b[i]) apply_row(tbl_b[i], $sformatf("b%0d", i));

    // 1 ns asynchronous reset pulse while locked, away from any clock edge
    #2;
    rst_n = 1'b0;
    #0.5;
    chk("arst_locked",  32'(locked),  32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_period",  32'(period),  32'd0);
    chk("arst_err",     32'(err),     32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    #0.5;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_locked",  32'(locked),  32'd0);
    chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("post_rst_err",     32'(err),     32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
